// File: rtl/fma_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-precision FMA unit among N
// requesters, with a watchdog that answers a hung operation with a qNaN error.
// The instantiating level drives the FMA's rst_n from ~rst so that a reset
// also flushes any completion still in flight inside the FMA.
module fma_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  input  logic [N*32-1:0] req_c,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic [IDW-1:0]  resp_id,
  output logic            resp_err,
  output logic            timeout_seen,
  output logic            busy,
  output logic            fma_start,
  output logic [31:0]     fma_a,
  output logic [31:0]     fma_b,
  output logic [31:0]     fma_c,
  input  logic [31:0]     fma_result,
  input  logic            fma_done
);

  localparam int unsigned CW       = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] id_q;
  logic [CW-1:0]  wd_q;
  logic           fma_start_q;
  logic [31:0]    a_q, b_q, c_q;
  logic           resp_valid_q;
  logic [31:0]    resp_data_q;
  logic           resp_err_q;
  logic           timeout_q;
  logic           busy_q;

  logic           gnt_any_c;
  logic [IDW-1:0] gnt_idx_c;
  logic [IDW-1:0] cand_c;

  logic [31:0]    a_arr [N];
  logic [31:0]    b_arr [N];
  logic [31:0]    c_arr [N];

  // Unpack the flat operand buses into per-requester words
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign a_arr[g] = req_a[32*g +: 32];
    assign b_arr[g] = req_b[32*g +: 32];
    assign c_arr[g] = req_c[32*g +: 32];
  end

  // Round-robin pick: first valid requester searching upward from last_q+1
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    cand_c    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand_c = IDW'((32'(last_q) + k) % N);
      if (!gnt_any_c && req_valid[cand_c]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = cand_c;
      end
    end
  end

  // Accept is combinational and only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && !rst && gnt_any_c) begin
      req_ready[gnt_idx_c] = 1'b1;
    end
  end

  // Sequencer FSM with registered outputs and watchdog.
  // wd_q is zero in the first WAIT cycle (one cycle after the start pulse);
  // firing at TIMEOUT-2 makes resp_valid rise exactly TIMEOUT cycles after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= IDW'(N - 1);
      id_q         <= '0;
      wd_q         <= '0;
      fma_start_q  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fma_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_any_c) begin
            a_q         <= a_arr[gnt_idx_c];
            b_q         <= b_arr[gnt_idx_c];
            c_q         <= c_arr[gnt_idx_c];
            id_q        <= gnt_idx_c;
            fma_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (fma_done) begin
            resp_data_q  <= fma_result;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (wd_q == CW'(TIMEOUT - 2)) begin
            resp_data_q  <= QNAN;
            resp_err_q   <= 1'b1;
            timeout_q    <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            wd_q <= wd_q + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            last_q       <= id_q;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fma_start    = fma_start_q;
  assign fma_a        = a_q;
  assign fma_b        = b_q;
  assign fma_c        = c_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_id      = id_q;
  assign resp_err     = resp_err_q;
  assign timeout_seen = timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fma_arbiter.sv
// Self-checking bench for fma_arbiter with a behavioural FMA and a
// round-robin scoreboard.
module tb_fma_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a, req_b, req_c;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic [IDW-1:0]  resp_id;
  logic            resp_err;
  logic            timeout_seen;
  logic            busy;
  logic            fma_start;
  logic [31:0]     fma_a, fma_b, fma_c;
  logic [31:0]     fma_result;
  logic            fma_done;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];
  logic [31:0] op_c [N];

  logic        mdl_done;
  logic [31:0] mdl_res;
  logic        mdl_pend;
  int          mdl_rem;
  logic        stray_done;
  int          lat;
  bit          hang;
  int          start_cnt;

  int n_cmp;
  int n_bad;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_a[32*g +: 32] = op_a[g];
    assign req_b[32*g +: 32] = op_b[g];
    assign req_c[32*g +: 32] = op_c[g];
  end

  assign fma_done   = mdl_done | stray_done;
  assign fma_result = mdl_res;

  fma_arbiter #(.N(N), .TIMEOUT(64), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
    .timeout_seen(timeout_seen), .busy(busy),
    .fma_start(fma_start), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_result(fma_result), .fma_done(fma_done)
  );

  // Bench FMA: real answers for the two known triples, a fixed mix otherwise
  function automatic logic [31:0] fma_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    if (a == 32'h40000000 && b == 32'h40400000 && c == 32'h40800000) return 32'h41200000;
    if (a == 32'h3F800000 && b == 32'h3F800000 && c == 32'h3F800000) return 32'h40000000;
    return (a ^ {b[15:0], b[31:16]}) + c;
  endfunction

  // FMA model: done arrives lat cycles after the start cycle, unless hung
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (rst) begin
      mdl_pend <= 1'b0;
      mdl_rem  <= 0;
    end else if (fma_start) begin
      start_cnt = start_cnt + 1;
      mdl_res <= fma_fn(fma_a, fma_b, fma_c);
      if (lat <= 1) begin
        mdl_done <= !hang;
        mdl_pend <= 1'b0;
      end else begin
        mdl_rem  <= lat - 1;
        mdl_pend <= 1'b1;
      end
    end else if (mdl_pend) begin
      if (mdl_rem == 1) begin
        mdl_done <= !hang;
        mdl_pend <= 1'b0;
      end else begin
        mdl_rem <= mdl_rem - 1;
      end
    end
  end

  task automatic pulse_reset();
    rst = 1'b1; req_valid = '0; resp_ready = 1'b1; stray_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one request and wait for its response (resp_ready held high)
  task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, output logic [31:0] d, output int rid,
                        output logic err, output int lat_obs, output bit ok);
    int k0;
    bit hs;
    op_a[id] = a; op_b[id] = b; op_c[id] = c;
    req_valid[id] = 1'b1; resp_ready = 1'b1;
    ok = 1'b0; d = '0; rid = -1; err = 1'bx; lat_obs = -1; k0 = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      hs = req_ready[id] && req_valid[id];
      if (hs) k0 = k;
      if (resp_valid) begin
        ok = 1'b1; d = resp_data; rid = int'(resp_id); err = resp_err; lat_obs = k - k0;
      end
      @(posedge clk); #1;
      if (hs) req_valid[id] = 1'b0;
      if (ok) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready);
    end
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_data, resp_id, resp_err, timeout_seen, busy,
         fma_start, fma_a, fma_b, fma_c} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h exp=0", {req_ready, resp_valid, resp_data, resp_id,
               resp_err, timeout_seen, busy, fma_start, fma_a, fma_b, fma_c});
    end
  endtask

  task automatic test_single();
    logic [31:0] d; int rid; logic err; int lo; bit ok; int s0;
    lat = 4; s0 = start_cnt;
    do_req(0, 32'h40000000, 32'h40400000, 32'h40800000, d, rid, err, lo, ok);
    n_cmp++;
    if (!ok || d !== 32'h41200000 || rid != 0 || err !== 1'b0) begin
      n_bad++; $display("FAIL single_resp got ok=%0d d=%h id=%0d err=%b exp d=41200000 id=0 err=0",
                        ok, d, rid, err);
    end
    n_cmp++;
    if (start_cnt - s0 != 1) begin
      n_bad++; $display("FAIL single_start_pulses got=%0d exp=1", start_cnt - s0);
    end
    n_cmp++;
    if (lo != 2 + 4) begin
      n_bad++; $display("FAIL single_latency got=%0d exp=6", lo);
    end
    n_cmp++;
    if ({fma_a, fma_b, fma_c} !== {32'h40000000, 32'h40400000, 32'h40800000}) begin
      n_bad++; $display("FAIL single_operands got=%h %h %h exp=40000000 40400000 40800000",
                        fma_a, fma_b, fma_c);
    end
  endtask

  task automatic test_round_robin();
    int g[$]; int r[$]; logic [31:0] dq[$];
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] hsv;
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = 32'h3F800000; op_b[i] = 32'h3F800000; op_c[i] = 32'h3F800000;
    end
    lat = $urandom_range(1, 5); req_valid = '1; resp_ready = 1'b1;
    for (int k = 0; k < 400 && r.size() < 5; k++) begin
      @(negedge clk);
      hsv = req_ready & req_valid;
      for (int i = 0; i < N; i++) if (hsv[i]) g.push_back(i);
      if (resp_valid) begin r.push_back(int'(resp_id)); dq.push_back(resp_data); end
      @(posedge clk); #1;
      if (r.size() >= 5) req_valid = '0;
    end
    n_cmp++;
    if (g.size() != 5 || r.size() != 5) begin
      n_bad++; $display("FAIL rr_counts got grants=%0d resps=%0d exp=5/5", g.size(), r.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < g.size() && i < r.size()) begin
        n_cmp++;
        if (g[i] != exp_g[i] || r[i] != exp_g[i] || dq[i] !== 32'h40000000) begin
          n_bad++; $display("FAIL rr_step%0d got grant=%0d id=%0d d=%h exp grant/id=%0d d=40000000",
                            i, g[i], r[i], dq[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, b0, c0, a1, b1, c1, d0; logic [IDW-1:0] id0; bit hs; bit got;
    a0 = $urandom; b0 = $urandom; c0 = $urandom;
    a1 = $urandom; b1 = $urandom; c1 = $urandom;
    lat = $urandom_range(1, 6); resp_ready = 1'b0;
    op_a[0] = a0; op_b[0] = b0; op_c[0] = c0; req_valid = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hs = req_ready[0];
      @(posedge clk); #1;
      if (hs) begin
        req_valid[0] = 1'b0;
        op_a[1] = a1; op_b[1] = b1; op_c[1] = c1; req_valid[1] = 1'b1;
        break;
      end
    end
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; break; end
    end
    d0 = resp_data; id0 = resp_id;
    n_cmp++;
    if (!got || d0 !== fma_fn(a0, b0, c0) || id0 !== IDW'(0)) begin
      n_bad++; $display("FAIL bp_first_resp got ok=%0d d=%h id=%0d exp d=%h id=0",
                        got, d0, id0, fma_fn(a0, b0, c0));
    end
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      n_cmp++;
      if ({resp_valid, resp_data, resp_id, req_ready} !== {1'b1, d0, id0, 4'b0000}) begin
        n_bad++; $display("FAIL bp_hold%0d got v=%b d=%h id=%0d rdy=%b exp v=1 d=%h id=%0d rdy=0000",
                          j, resp_valid, resp_data, resp_id, req_ready, d0, id0);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL bp_next_grant got=%b exp=0010", req_ready);
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        n_cmp++;
        if (resp_id !== IDW'(1) || resp_data !== fma_fn(a1, b1, c1) || resp_err !== 1'b0) begin
          n_bad++; $display("FAIL bp_second_resp got id=%0d d=%h err=%b exp id=1 d=%h err=0",
                            resp_id, resp_data, resp_err, fma_fn(a1, b1, c1));
        end
        @(posedge clk); #1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL bp_second_timeout got=none exp=response"); end
  endtask

  task automatic test_timeout();
    logic [31:0] d, a, b, c; int rid; logic err; int lo; bit ok;
    hang = 1'b1; lat = 3;
    do_req(2, $urandom, $urandom, $urandom, d, rid, err, lo, ok);
    n_cmp++;
    if (!ok || d !== 32'h7FC00000 || rid != 2 || err !== 1'b1) begin
      n_bad++; $display("FAIL to_resp got ok=%0d d=%h id=%0d err=%b exp d=7fc00000 id=2 err=1",
                        ok, d, rid, err);
    end
    n_cmp++;
    if (lo != 64 + 1) begin
      n_bad++; $display("FAIL to_cycles_after_start got=%0d exp=64", lo - 1);
    end
    n_cmp++;
    if (timeout_seen !== 1'b1) begin
      n_bad++; $display("FAIL to_sticky_set got=%b exp=1", timeout_seen);
    end
    hang = 1'b0; lat = $urandom_range(1, 6);
    a = $urandom; b = $urandom; c = $urandom;
    do_req(3, a, b, c, d, rid, err, lo, ok);
    n_cmp++;
    if (!ok || d !== fma_fn(a, b, c) || rid != 3 || err !== 1'b0 || timeout_seen !== 1'b1) begin
      n_bad++; $display("FAIL to_recover got ok=%0d d=%h id=%0d err=%b ts=%b exp d=%h id=3 err=0 ts=1",
                        ok, d, rid, err, timeout_seen, fma_fn(a, b, c));
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d; int rid; logic err; int lo; bit ok; bit hs; bit started; bit seen;
    lat = 2;
    do_req(2, $urandom, $urandom, $urandom, d, rid, err, lo, ok);
    lat = 20; started = 1'b0;
    op_a[3] = $urandom; op_b[3] = $urandom; op_c[3] = $urandom; req_valid[3] = 1'b1;
    for (int k = 0; k < 20 && !started; k++) begin
      @(negedge clk);
      hs = req_ready[3]; started = fma_start;
      @(posedge clk); #1;
      if (hs) req_valid[3] = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, resp_data, resp_id, resp_err, timeout_seen, busy,
         fma_start, fma_a, fma_b, fma_c} !== '0 || !started) begin
      n_bad++;
      $display("FAIL rst_wait_outputs got=%h started=%0d exp=0", {req_ready, resp_valid, resp_data,
               resp_id, resp_err, timeout_seen, busy, fma_start, fma_a, fma_b, fma_c}, started);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rst_wait_dropped got=response exp=none"); end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL rst_wait_priority got=%b exp=0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0; lat = 2;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_valid) begin @(posedge clk); #1; break; end
    end
  endtask

  task automatic test_stray_done();
    logic [31:0] d, a, b, c; int rid; logic err; int lo; bit ok;
    req_valid = '0;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL stray_done%0d got v=%b busy=%b exp v=0 busy=0", j, resp_valid, busy);
      end
    end
    a = $urandom; b = $urandom; c = $urandom; lat = 3;
    do_req(1, a, b, c, d, rid, err, lo, ok);
    n_cmp++;
    if (!ok || d !== fma_fn(a, b, c) || rid != 1 || err !== 1'b0) begin
      n_bad++; $display("FAIL stray_after got ok=%0d d=%h id=%0d err=%b exp d=%h id=1 err=0",
                        ok, d, rid, err, fma_fn(a, b, c));
    end
  endtask

  task automatic test_random();
    int exp_id[$]; logic [31:0] exp_d[$];
    int last; int eg; int eid; logic [31:0] ed;
    logic [N-1:0] exp_rdy; logic [N-1:0] hs;
    pulse_reset();
    last = N - 1;
    for (int cyc = 0; cyc < 450; cyc++) begin
      @(negedge clk);
      hs = '0; eg = -1; exp_rdy = '0;
      if (exp_id.size() == 0) begin
        for (int j = 1; j <= N; j++) begin
          if (eg < 0 && req_valid[(last + j) % N]) eg = (last + j) % N;
        end
        if (eg >= 0) exp_rdy = N'(1) << eg;
      end
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_bad++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
      end else if (eg >= 0) begin
        exp_id.push_back(eg);
        exp_d.push_back(fma_fn(op_a[eg], op_b[eg], op_c[eg]));
        hs[eg] = 1'b1;
      end
      if (resp_valid && resp_ready) begin
        n_cmp++;
        if (exp_id.size() == 0) begin
          n_bad++; $display("FAIL rand_resp cyc=%0d got=unexpected id=%0d exp=none", cyc, resp_id);
        end else begin
          eid = exp_id.pop_front(); ed = exp_d.pop_front(); last = eid;
          if ({resp_id, resp_data, resp_err} !== {IDW'(eid), ed, 1'b0}) begin
            n_bad++; $display("FAIL rand_resp cyc=%0d got id=%0d d=%h err=%b exp id=%0d d=%h err=0",
                              cyc, resp_id, resp_data, resp_err, eid, ed);
          end
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !req_valid[i]) begin
          if (cyc < 300 && $urandom_range(0, 1) == 1) begin
            req_valid[i] = 1'b1; op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = $urandom;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      resp_ready = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 6);
    end
    n_cmp++;
    if (exp_id.size() != 0) begin
      n_bad++; $display("FAIL rand_drain got pending=%0d exp=0", exp_id.size());
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; start_cnt = 0;
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0; stray_done = 1'b0;
    hang = 1'b0; lat = 3;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_stray_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
